// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the single-cycle MIPS control unit: opcodes, functs,
// ALUOp and ALUControl codes, and the packed main-decoder control word.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alucontrol_t;

    // Field order matches the main-decoder table so a packed literal reads
    // left to right as RegWrite..Jump, ALUOp.
    typedef struct packed {
        logic       regwrite;
        logic       regdst;
        logic       alusrc;
        logic       branch;
        logic       memwrite;
        logic       memtoreg;
        logic       jump;
        logic [1:0] aluop;
    } ctrl_t;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU decoder: ALUOp plus funct to 3-bit ALUControl.
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] i_aluop,
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_control
);

    always_comb begin
        o_alu_control = ALU_AND;
        if (i_aluop[1]) begin
            // Both 10 and 11 fall through to the funct decode.
            case (i_funct)
                F_ADD:   o_alu_control = ALU_ADD;
                F_SUB:   o_alu_control = ALU_SUB;
                F_AND:   o_alu_control = ALU_AND;
                F_OR:    o_alu_control = ALU_OR;
                F_SLT:   o_alu_control = ALU_SLT;
                default: o_alu_control = ALU_AND;
            endcase
        end else if (i_aluop[0]) begin
            o_alu_control = ALU_SUB;
        end else begin
            o_alu_control = ALU_ADD;
        end
    end

endmodule

// File: rtl/mips_full_controller.sv
// MIPS control unit: main decoder and ALU decoder feeding a single output
// register stage, so every strobe appears one clock after its inputs.
module mips_full_controller
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrc,
    output logic       PCSrc,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       Jump,
    output logic [2:0] ALUControl,
    output logic       Branch,
    output logic [1:0] ALUOp
);

    ctrl_t      w_ctrl;
    logic [2:0] w_alu_control;
    logic       w_pcsrc;

    ctrl_t      r_ctrl;
    logic [2:0] r_alu_control;
    logic       r_pcsrc;

    always_comb begin
        w_ctrl = '0;
        case (opcode)
            OP_RTYPE: w_ctrl = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_FUNCT};
            OP_LW:    w_ctrl = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ALUOP_ADD};
            OP_SW:    w_ctrl = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ALUOP_ADD};
            OP_BEQ:   w_ctrl = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALUOP_SUB};
            OP_ADDI:  w_ctrl = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_ADD};
            OP_J:     w_ctrl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALUOP_ADD};
            default:  w_ctrl = '0;
        endcase
    end

    assign w_pcsrc = w_ctrl.branch & zero;

    mips_alu_decoder u_alu_decoder (
        .i_aluop       (w_ctrl.aluop),
        .i_funct       (funct),
        .o_alu_control (w_alu_control)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl        <= '0;
            r_alu_control <= '0;
            r_pcsrc       <= 1'b0;
        end else begin
            r_ctrl        <= w_ctrl;
            r_alu_control <= w_alu_control;
            r_pcsrc       <= w_pcsrc;
        end
    end

    assign RegWrite   = r_ctrl.regwrite;
    assign RegDst     = r_ctrl.regdst;
    assign ALUSrc     = r_ctrl.alusrc;
    assign Branch     = r_ctrl.branch;
    assign MemWrite   = r_ctrl.memwrite;
    assign MemtoReg   = r_ctrl.memtoreg;
    assign Jump       = r_ctrl.jump;
    assign ALUOp      = r_ctrl.aluop;
    assign ALUControl = r_alu_control;
    assign PCSrc      = r_pcsrc;

endmodule

// File: tb/tb_mips_full_controller.sv
// Directed bench for mips_full_controller: hand-computed vectors checked
// with immediate assertions one clock after each input change.
module tb_mips_full_controller;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       RegWrite, RegDst, ALUSrc, PCSrc, MemWrite, MemtoReg, Jump, Branch;
    logic [2:0] ALUControl;
    logic [1:0] ALUOp;

    int total = 0;
    int bad   = 0;

    mips_full_controller dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .RegWrite   (RegWrite),
        .RegDst     (RegDst),
        .ALUSrc     (ALUSrc),
        .PCSrc      (PCSrc),
        .MemWrite   (MemWrite),
        .MemtoReg   (MemtoReg),
        .Jump       (Jump),
        .ALUControl (ALUControl),
        .Branch     (Branch),
        .ALUOp      (ALUOp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Observed word: {RegWrite,RegDst,ALUSrc,Branch,MemWrite,MemtoReg,Jump,ALUOp}, ALUControl, PCSrc
    function automatic logic [12:0] obs_word();
        return {RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemtoReg, Jump, ALUOp, ALUControl, PCSrc};
    endfunction

    task automatic chk(input string tag, input logic [8:0] ctrl, input logic [2:0] aluc, input logic pcs);
        logic [12:0] o;
        logic [12:0] e;
        o = obs_word();
        e = {ctrl, aluc, pcs};
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s obs=%b exp=%b", tag, o, e);
        end
    endtask

    // Drive inputs on the falling edge, then sample 1 time unit after the capturing rising edge.
    task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic z);
        @(negedge clk);
        opcode = op;
        funct  = fn;
        zero   = z;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset  = 1'b1;
        opcode = 6'b000000;
        funct  = 6'b100000;
        zero   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hold", 9'b000000000, 3'b000, 1'b0);

        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("first_edge_rtype_add", 9'b110000010, 3'b010, 1'b0);

        // R-type funct sweep
        step(6'b000000, 6'b100010, 1'b0);
        chk("rtype_sub", 9'b110000010, 3'b110, 1'b0);
        step(6'b000000, 6'b100100, 1'b0);
        chk("rtype_and", 9'b110000010, 3'b000, 1'b0);
        step(6'b000000, 6'b100101, 1'b0);
        chk("rtype_or", 9'b110000010, 3'b001, 1'b0);
        step(6'b000000, 6'b101010, 1'b0);
        chk("rtype_slt", 9'b110000010, 3'b111, 1'b0);
        step(6'b000000, 6'b100000, 1'b0);
        chk("rtype_add", 9'b110000010, 3'b010, 1'b0);
        step(6'b000000, 6'b111111, 1'b0);
        chk("rtype_bad_funct", 9'b110000010, 3'b000, 1'b0);

        // Input change must not reach outputs before the next edge
        @(negedge clk);
        funct = 6'b101010;
        #1;
        chk("latency_hold", 9'b110000010, 3'b000, 1'b0);
        @(posedge clk);
        #1;
        chk("latency_update", 9'b110000010, 3'b111, 1'b0);

        step(6'b100011, 6'b101010, 1'b0);
        chk("lw", 9'b101001000, 3'b010, 1'b0);
        step(6'b101011, 6'b100010, 1'b1);
        chk("sw", 9'b001010000, 3'b010, 1'b0);
        step(6'b001000, 6'b100100, 1'b0);
        chk("addi", 9'b101000000, 3'b010, 1'b0);

        step(6'b000100, 6'b100101, 1'b1);
        chk("beq_taken", 9'b000100001, 3'b110, 1'b1);
        step(6'b000100, 6'b100101, 1'b0);
        chk("beq_not_taken", 9'b000100001, 3'b110, 1'b0);
        step(6'b000100, 6'b100000, 1'b1);
        chk("beq_taken_again", 9'b000100001, 3'b110, 1'b1);

        step(6'b000010, 6'b101010, 1'b1);
        chk("j_zero1", 9'b000000100, 3'b010, 1'b0);
        step(6'b000010, 6'b101010, 1'b0);
        chk("j_zero0", 9'b000000100, 3'b010, 1'b0);

        step(6'b111111, 6'b101010, 1'b1);
        chk("illegal_op", 9'b000000000, 3'b010, 1'b0);
        step(6'b000001, 6'b100010, 1'b1);
        chk("illegal_op2", 9'b000000000, 3'b010, 1'b0);

        // Mid-cycle asynchronous reset from a non-zero output state
        step(6'b000000, 6'b101010, 1'b0);
        chk("pre_reset_rtype", 9'b110000010, 3'b111, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset", 9'b000000000, 3'b000, 1'b0);
        @(posedge clk);
        #1;
        chk("reset_held_edge", 9'b000000000, 3'b000, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset_rtype", 9'b110000010, 3'b111, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
